// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receive port, the transmit path and the
// CU address decode.
//   uart_rx_state_t  : receiver FSM state encoding
//   UART_DATA_BITS   : data bits per frame
//   UART_IO_ADDR     : memory-mapped UART data address (LOAD = rx, STORE = tx)
//   uart_even_parity : even-parity bit for a data byte
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic [7:0]  UART_IO_ADDR   = 8'hFE;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StParity
    } uart_rx_state_t;

    // Bit value that makes the total number of ones (data + parity) even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Free-running bit-period counter shared by the UART receive and transmit
// paths. Counts up by one per clock from 0; the owner clears it at bit
// boundaries.
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high reset (count -> 0)
//   clear in   force the count to 0 on the next edge
//   half  out  count == CLKS_PER_BIT/2 - 1 (mid-bit point from a start edge)
//   full  out  count == CLKS_PER_BIT - 1   (one whole bit period elapsed)
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half,
    output logic full
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    always_comb begin
        half = (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1));
        full = (cnt_q == CntW'(CLKS_PER_BIT - 1));
    end

endmodule

// File: rtl/uart_rx_port.sv
// ---------------------------------------------------------------------------
// uart_rx_port
// UART receiver for the Mini-CPU. Deserialises 8N1 frames (8E1 when built with
// UART_RX_PARITY_EN defined) from rx into a one-byte holding register that the
// CU consumes with rx_read on LOAD from UART_IO_ADDR.
// CLKS_PER_BIT must be at least 4.
// Ports:
//   clk         in   system clock, posedge
//   reset       in   synchronous active-high reset
//   rx          in   asynchronous serial line, idle high
//   rx_read     in   strobe: consume the holding byte
//   err_clr     in   strobe: clear the sticky error flags
//   rx_data     out  holding register (LSB received first)
//   rx_valid    out  holding register holds an unread byte
//   rx_busy     out  frame in progress
//   parity_err  out  sticky even-parity mismatch (UART_RX_PARITY_EN only)
//   framing_err out  sticky: stop bit sampled low
//   overrun     out  sticky: frame completed while rx_valid was already set
// ---------------------------------------------------------------------------
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_read,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       framing_err,
    output logic       overrun
);

    // Input synchroniser plus edge-detect delay; all idle-high after reset so
    // reset itself never looks like a start edge.
    logic rx_meta, rx_s, rx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    uart_rx_state_t state_q, state_d;

    logic cnt_clear, cnt_half, cnt_full;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .half (cnt_half),
        .full (cnt_full)
    );

    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [7:0]                rx_data_q;
    logic                      rx_valid_q;
    logic                      framing_err_q;
    logic                      overrun_q;

    logic fall_edge, last_bit;
    logic start_ok, data_sample, stop_sample, frame_done;

    assign fall_edge = rx_d & ~rx_s;
    assign last_bit  = (bit_idx_q == 3'(UART_DATA_BITS - 1));

`ifdef UART_RX_PARITY_EN
    logic par_sample;
    logic parity_bad_q;
    logic parity_err_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (fall_edge) state_d = StStart;
            end
            StStart: begin
                // A start bit that is no longer low at mid-bit is a glitch.
                if (cnt_half) state_d = rx_s ? StIdle : StData;
            end
            StData: begin
                if (cnt_full && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_full) state_d = StStop;
            end
`endif
            StStop: begin
                if (cnt_full) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / strobe decode.
    always_comb begin
        cnt_clear   = 1'b0;
        start_ok    = 1'b0;
        data_sample = 1'b0;
        stop_sample = 1'b0;
        rx_busy     = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // Holding the count at 0 makes START begin counting from 0.
                cnt_clear = 1'b1;
                rx_busy   = 1'b0;
            end
            StStart: begin
                if (cnt_half) begin
                    cnt_clear = 1'b1;
                    start_ok  = ~rx_s;
                end
            end
            StData: begin
                if (cnt_full) begin
                    cnt_clear   = 1'b1;
                    data_sample = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_full) begin
                    cnt_clear  = 1'b1;
                    par_sample = 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_full) begin
                    cnt_clear   = 1'b1;
                    stop_sample = 1'b1;
                end
            end
            default: rx_busy = 1'b0;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign frame_done = stop_sample & rx_s & ~parity_bad_q;
`else
    assign frame_done = stop_sample & rx_s;
`endif

    // Datapath: shift register, holding register and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q  <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_q <= 1'b0;
`endif
            end

            if (data_sample) begin
                shift_q[bit_idx_q] <= rx_s;
                bit_idx_q          <= bit_idx_q + 3'd1;
            end

            // Clear first so a same-cycle set below takes precedence.
            if (err_clr) begin
                framing_err_q <= 1'b0;
                overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q  <= 1'b0;
`endif
            end

`ifdef UART_RX_PARITY_EN
            if (par_sample && (uart_even_parity(shift_q) != rx_s)) begin
                parity_bad_q <= 1'b1;
                parity_err_q <= 1'b1;
            end
`endif

            if (stop_sample && !rx_s) begin
                framing_err_q <= 1'b1;
            end

            if (frame_done) begin
                // A read in the completion cycle frees the register for the new byte.
                if (!rx_valid_q || rx_read) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_read && rx_valid_q) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_port.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_port
// Directed testbench for uart_rx_port with CLKS_PER_BIT = 16. Build with
// UART_RX_PARITY_EN defined to exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_uart_rx_port;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Loop cycle at which rx_valid is first seen: 3 clocks sync/edge detect,
    // half a bit to the start centre, then one bit per remaining frame bit.
    localparam int VALID_CYCLE = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;
    // Cycle in which the stop bit is sampled (completion cycle).
    localparam int DONE_CYCLE  = VALID_CYCLE - 1;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_read;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_tests;
    int n_fail;
    int first_valid;
    logic busy_mid;

    uart_rx_port #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_read    (rx_read),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rx      = 1'b1;
        rx_read = 1'b0;
        err_clr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
    endtask

    // Drives one frame; rx_read / err_clr pulse in cycle read_c / clr_c (-1 = never).
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int read_c, input int clr_c);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, data, 1'b0};
`else
        bits = {par, stop, data, 1'b0};
`endif
        first_valid = -1;
        busy_mid    = 1'b0;
        for (int c = 0; c < FRAME_BITS * CPB; c++) begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (c == 5 * CPB) busy_mid = rx_busy;
            rx      = bits[c / CPB];
            rx_read = (c == read_c);
            err_clr = (c == clr_c);
        end
        tick(1);
        rx_read = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got data=%h valid=%b busy=%b want 00 0 0",
                     rx_data, rx_valid, rx_busy);
        end
        n_tests++;
        if (framing_err !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got fe=%b ov=%b want 0 0", framing_err, overrun);
        end
`ifdef UART_RX_PARITY_EN
        n_tests++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_perr got %b want 0", parity_err);
        end
`endif
    endtask

    task automatic test_basic();
        send_frame(8'hA5, ^8'hA5, 1'b1, -1, -1);
        n_tests++;
        if (busy_mid !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_busy got %b want 1", busy_mid);
        end
        n_tests++;
        if (first_valid < VALID_CYCLE - 8 || first_valid > VALID_CYCLE) begin
            n_fail++;
            $display("FAIL a5_latency got %0d want %0d..%0d", first_valid,
                     VALID_CYCLE - 8, VALID_CYCLE);
        end
        n_tests++;
        if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_data got %h/%b want a5/1", rx_data, rx_valid);
        end
        n_tests++;
        if (framing_err !== 1'b0 || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_flags got fe=%b busy=%b want 0 0", framing_err, rx_busy);
        end
    endtask

    task automatic test_read();
        do_reset();
        send_frame(8'h3C, ^8'h3C, 1'b1, -1, -1);
        n_tests++;
        if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL 3c_data got %h/%b want 3c/1", rx_data, rx_valid);
        end
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_clears got %b want 0", rx_valid);
        end
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL read_idle got %b/%h want 0/3c", rx_valid, rx_data);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(8'h11, ^8'h11, 1'b1, -1, -1);
        send_frame(8'h22, ^8'h22, 1'b1, -1, -1);
        n_tests++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set got %h/%b/%b want 11/1/1", rx_data, rx_valid, overrun);
        end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b0 || rx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_clr got %b/%h want 0/11", overrun, rx_data);
        end
        send_frame(8'h22, ^8'h22, 1'b1, DONE_CYCLE, -1);
        n_tests++;
        if (rx_data !== 8'h22 || rx_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL read_on_done got %h/%b/%b want 22/1/0", rx_data, rx_valid, overrun);
        end
        // err_clr in the same cycle as an overrun: the set must win.
        send_frame(8'h33, ^8'h33, 1'b1, -1, DONE_CYCLE);
        n_tests++;
        if (overrun !== 1'b1 || rx_data !== 8'h22) begin
            n_fail++;
            $display("FAIL clr_vs_set got %b/%h want 1/22", overrun, rx_data);
        end
    endtask

    task automatic test_framing();
        do_reset();
        send_frame(8'h55, ^8'h55, 1'b0, -1, -1);
        n_tests++;
        if (framing_err !== 1'b1 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL framing got fe=%b valid=%b want 1 0", framing_err, rx_valid);
        end
        tick(40);
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_redetect got busy=%b want 0", rx_busy);
        end
        rx = 1'b1;
        tick(20);
        send_frame(8'h81, ^8'h81, 1'b1, -1, -1);
        n_tests++;
        if (rx_data !== 8'h81 || rx_valid !== 1'b1 || framing_err !== 1'b1) begin
            n_fail++;
            $display("FAIL after_break got %h/%b fe=%b want 81/1 fe=1",
                     rx_data, rx_valid, framing_err);
        end
    endtask

    task automatic test_glitch_reset();
        do_reset();
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        n_tests++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_detect got busy=%b want 1", rx_busy);
        end
        tick(30);
        n_tests++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0)
        begin
            n_fail++;
            $display("FAIL glitch_idle got busy=%b v=%b fe=%b ov=%b want 0 0 0 0",
                     rx_busy, rx_valid, framing_err, overrun);
        end
        // Put non-reset values in every output before resetting mid-frame.
        send_frame(8'h5A, ^8'h5A, 1'b1, -1, -1);
        send_frame(8'hF0, ^8'hF0, 1'b0, -1, -1);
        rx = 1'b1;
        tick(20);
        rx = 1'b0;
        tick(40);
        n_tests++;
        if (rx_busy !== 1'b1 || rx_data !== 8'h5A || framing_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got busy=%b data=%h fe=%b want 1 5a 1",
                     rx_busy, rx_data, framing_err);
        end
        reset = 1'b1;
        rx    = 1'b1;
        tick(1);
        n_tests++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00 ||
            framing_err !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b v=%b d=%h fe=%b ov=%b want 0 0 00 0 0",
                     rx_busy, rx_valid, rx_data, framing_err, overrun);
        end
        reset = 1'b0;
        tick(20);
        send_frame(8'h7E, ^8'h7E, 1'b1, -1, -1);
        n_tests++;
        if (rx_data !== 8'h7E || rx_valid !== 1'b1 || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got %h/%b fe=%b want 7e/1 fe=0",
                     rx_data, rx_valid, framing_err);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_frame(8'h03, 1'b1, 1'b1, -1, -1);
        n_tests++;
        if (parity_err !== 1'b1 || rx_valid !== 1'b0 || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad got pe=%b v=%b fe=%b want 1 0 0",
                     parity_err, rx_valid, framing_err);
        end
        send_frame(8'h03, 1'b0, 1'b1, -1, -1);
        n_tests++;
        if (rx_data !== 8'h03 || rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_good got %h/%b want 03/1", rx_data, rx_valid);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_read();
        test_overrun();
        test_framing();
        test_glitch_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Serial UART receiver feeding the Mini-CPU. It is the receive-side counterpart of the existing UART transmit path (STORE to address 0xFE).
- Deserialises 8N1 frames from the `rx` pin into a one-byte holding register with a valid flag.
- The CU reads the byte by pulsing `rx_read`, issued on LOAD from address 0xFE.
- Sticky framing and overrun flags report line errors to software.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per bit; overridable (e.g. 16) for simulation; must be at least 4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- rx_read  in  1  one-cycle strobe from the CU; consumes the holding byte.
- err_clr  in  1  one-cycle strobe; clears `framing_err` and `overrun`.
- rx_data  out  8  holding register, LSB received first.
- rx_valid  out  1  holding register contains an unread byte.
- rx_busy  out  1  a frame is in progress (state other than IDLE).
- framing_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a frame completed while `rx_valid` was already 1.

Behaviour:
- Reset: state IDLE; baud counter 0; bit index 0; shift register 0x00; `rx_data`=0x00; `rx_valid`=0; `rx_busy`=0; `framing_err`=0; `overrun`=0.
  - Both synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame immediately; no partial byte is ever exposed.
- Input path: `rx` passes through a 2-flop synchroniser (`rx_s`), plus one delay flop (`rx_d`) for edge detection. Synchroniser latency is 2 clocks.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_d`=1 and `rx_s`=0 (falling edge), go to START with counter=0.
  - START: count to CLKS_PER_BIT/2−1, then resample.
    - If `rx_s`=0: go to DATA, counter=0, bit index=0.
    - Otherwise: glitch; return to IDLE with no flags changed.
  - DATA: when counter reaches CLKS_PER_BIT−1, sample `rx_s` into shift bit[index] (LSB first) and reset counter.
    - After index 7: go to STOP.
  - STOP: when counter reaches CLKS_PER_BIT−1, sample the stop bit.
    - High: byte complete (see holding rules).
    - Low: set `framing_err`, discard the byte, return to IDLE.
    - Because IDLE requires a falling edge, a held-low line (break) is not re-detected until it returns high.
- Sampling point: each bit is sampled at its nominal centre, ±1 clock.
- Holding rules on byte complete (evaluated in the same cycle as `rx_read`):
  - `rx_valid`=0: load `rx_data`; `rx_valid`←1.
  - `rx_valid`=1 and `rx_read`=0: new byte dropped; `rx_data` kept; `overrun`←1.
  - `rx_valid`=1 and `rx_read`=1: load the new byte; `rx_valid` stays 1; no overrun.
- `rx_read` with `rx_valid`=0: no effect; `rx_data` unchanged.
- `rx_read` with `rx_valid`=1 and no completion: `rx_valid`←0 on the next edge.
- Timing visibility:
  - `rx_data` is stable whenever `rx_valid`=1.
  - A completion sets `rx_valid` one clock after the stop-bit sample.
- `err_clr` and a same-cycle error set: the set wins (the flag stays 1).
- End-to-end latency: `rx_valid` rises ≈9.5×CLKS_PER_BIT + 3 clocks after the start-bit falling edge on `rx`.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at the same mid-bit point.
  - Even parity is checked over the 8 data bits.
  - Adds output `parity_err` (1 bit, sticky, cleared by `err_clr`, reset 0).
  - On mismatch, `parity_err`←1 and the byte is discarded. The STOP state is still traversed, and a framing check still applies.
  - Frame length becomes 11 bits.
- Undefined: 8N1 only; no PARITY state and no `parity_err` port.

Decomposition:
- Shared package `uart_pkg`:
  - State enum `uart_rx_state_t` (IDLE, START, DATA, STOP, PARITY).
  - Constants UART_DATA_BITS=8 and UART_IO_ADDR=8'hFE, shared with the CU and the TX side.
- Sub-module `uart_baud_cnt`: counter with `clear`, `half` and `full` terminal flags. Reused by the TX path.

Test Plan (CLKS_PER_BIT=16):
1. Send 0xA5 as 8N1 → `rx_busy` high during the frame; `rx_valid`=1 with `rx_data`=0xA5 within 155 clocks of the start edge; `framing_err`=0.
2. Send 0x3C, then pulse `rx_read` → `rx_valid` goes 0 on the next clock. A second `rx_read` causes no change.
3. Send 0x11 then 0x22 with no read → `rx_data` stays 0x11 and `overrun`=1. Then pulse `err_clr` → `overrun`=0. Repeat with `rx_read` in the completion cycle of 0x22 → `rx_data`=0x22, `rx_valid`=1, `overrun`=0.
4. Send 0x55 with the stop bit driven low → `framing_err`=1 and `rx_valid` stays 0. No new frame is detected until `rx` returns high and falls again.
5. Drive a 5-clock low glitch on idle `rx` → returns to IDLE; no valid or error flags. Separately, assert `reset` mid-frame → all outputs return to reset values, and the next clean frame 0x7E is received correctly.
6. (UART_RX_PARITY_EN) Send 0x03 with parity=1 → `parity_err`=1 and `rx_valid`=0. Send 0x03 with parity=0 → `rx_data`=0x03.
